// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32I opcodes, ALU op codes shared with the ALU, immediate formats and the issue payload
// Optional ILLEGAL_TRAP_EN adds the illegal flag to the issue payload.
package riscv_pkg;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [5:0] ALU_ADD  = 6'd0;
  localparam logic [5:0] ALU_SUB  = 6'd1;
  localparam logic [5:0] ALU_XOR  = 6'd2;
  localparam logic [5:0] ALU_SLL  = 6'd3;
  localparam logic [5:0] ALU_SRL  = 6'd4;
  localparam logic [5:0] ALU_SRA  = 6'd5;
  localparam logic [5:0] ALU_AND  = 6'd6;
  localparam logic [5:0] ALU_OR   = 6'd7;
  localparam logic [5:0] ALU_SLT  = 6'd8;
  localparam logic [5:0] ALU_BEQ  = 6'd9;
  localparam logic [5:0] ALU_BNE  = 6'd10;
  localparam logic [5:0] ALU_BLT  = 6'd11;
  localparam logic [5:0] ALU_BGE  = 6'd12;
  localparam logic [5:0] ALU_SLTU = 6'd13;
  localparam logic [5:0] ALU_BLTU = 6'd14;
  localparam logic [5:0] ALU_BGEU = 6'd15;
  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;
  typedef struct packed {
    logic [31:0] srca;
    logic [31:0] srcb;
    logic [31:0] imm;
    logic [31:0] store_data;
    logic [31:0] pc;
    logic [5:0]  alu_ctrl;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        is_branch;
    logic        is_jump;
`ifdef ILLEGAL_TRAP_EN
    logic        illegal;
`endif
  } issue_t;
  function automatic logic [31:0] imm_gen(input logic [31:0] i, input imm_fmt_e f);
    return f == IMM_I ? {{20{i[31]}}, i[31:20]} :
           f == IMM_S ? {{20{i[31]}}, i[31:25], i[11:7]} :
           f == IMM_B ? {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0} :
           f == IMM_U ? {i[31:12], 12'b0} :
           f == IMM_J ? {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0} : 32'b0;
  endfunction
  // alt is funct7[5] where it selects sub/sra, otherwise 0
  function automatic logic [5:0] arith_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
  function automatic logic [5:0] branch_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_BEQ;
      3'b001:  return ALU_BNE;
      3'b100:  return ALU_BLT;
      3'b101:  return ALU_BGE;
      3'b110:  return ALU_BLTU;
      default: return ALU_BGEU;
    endcase
  endfunction
endpackage

// File: rtl/alu_issue_stage_if.sv
// alu_issue_stage_if: input (decode side) and output (EX side) valid/ready buses of the issue stage
// slave = issue stage view, master = producer/consumer (testbench) view.
// Optional ILLEGAL_TRAP_EN adds the illegal output.
interface alu_issue_stage_if;
  logic        inValid;
  logic        inReady;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1Data;
  logic [31:0] rs2Data;
  logic        outValid;
  logic        outReady;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic [5:0]  aluCtrl;
  logic [31:0] imm;
  logic [31:0] storeData;
  logic [31:0] pcOut;
  logic [4:0]  rd;
  logic        regWrite;
  logic        memRead;
  logic        memWrite;
  logic        isBranch;
  logic        isJump;
`ifdef ILLEGAL_TRAP_EN
  logic        illegal;
`endif
  modport slave (
`ifdef ILLEGAL_TRAP_EN
    output illegal,
`endif
    input  inValid, instr, pc, rs1Data, rs2Data, outReady,
    output inReady, outValid, srca, srcb, aluCtrl, imm, storeData, pcOut, rd,
    output regWrite, memRead, memWrite, isBranch, isJump
  );
  modport master (
`ifdef ILLEGAL_TRAP_EN
    input  illegal,
`endif
    output inValid, instr, pc, rs1Data, rs2Data, outReady,
    input  inReady, outValid, srca, srcb, aluCtrl, imm, storeData, pcOut, rd,
    input  regWrite, memRead, memWrite, isBranch, isJump
  );
endinterface

// File: rtl/alu_issue_decode.sv
// alu_issue_decode: combinational RV32I instr/pc/rs1/rs2 -> ALU issue payload
// Ports: instr, pc, rs1_data, rs2_data in; payload out.
// With ILLEGAL_TRAP_EN, malformed encodings raise payload.illegal; they always issue as a NOP.
module alu_issue_decode
  import riscv_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output issue_t      payload
);
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic shift, bad;
  assign opc = instr[6:0];
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];
  assign shift = f3 == 3'b001 || f3 == 3'b101;
  always_comb begin
    payload = '0;
    bad = 1'b0;
    payload.pc = pc;
    case (opc)
      OPC_OP: begin
        payload.srca = rs1_data;
        payload.srcb = shift ? {27'b0, rs2_data[4:0]} : rs2_data;
        payload.alu_ctrl = arith_op(f3, f7[5]);
        payload.reg_write = 1'b1;
`ifdef ILLEGAL_TRAP_EN
        bad = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
`endif
      end
      OPC_OPIMM: begin
        payload.srca = rs1_data;
        payload.imm = imm_gen(instr, IMM_I);
        payload.srcb = shift ? {27'b0, instr[24:20]} : payload.imm;
        payload.alu_ctrl = arith_op(f3, shift & f7[5]);
        payload.reg_write = 1'b1;
`ifdef ILLEGAL_TRAP_EN
        bad = shift && !(f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'b101));
`endif
      end
      OPC_LOAD: begin
        payload.srca = rs1_data;
        payload.imm = imm_gen(instr, IMM_I);
        payload.srcb = payload.imm;
        payload.mem_read = 1'b1;
        payload.reg_write = 1'b1;
      end
      OPC_STORE: begin
        payload.srca = rs1_data;
        payload.imm = imm_gen(instr, IMM_S);
        payload.srcb = payload.imm;
        payload.store_data = rs2_data;
        payload.mem_write = 1'b1;
      end
      OPC_BRANCH: begin
        payload.srca = rs1_data;
        payload.srcb = rs2_data;
        payload.imm = imm_gen(instr, IMM_B);
        payload.alu_ctrl = branch_op(f3);
        payload.is_branch = 1'b1;
        bad = f3[2:1] == 2'b01;
      end
      OPC_LUI, OPC_AUIPC: begin
        payload.srca = opc == OPC_AUIPC ? pc : 32'b0;
        payload.imm = imm_gen(instr, IMM_U);
        payload.srcb = payload.imm;
        payload.reg_write = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        payload.srca = pc;
        payload.srcb = 32'd4;
        payload.imm = imm_gen(instr, opc == OPC_JAL ? IMM_J : IMM_I);
        payload.is_jump = 1'b1;
        payload.reg_write = 1'b1;
`ifdef ILLEGAL_TRAP_EN
        bad = opc == OPC_JALR && f3 != 3'b000;
`endif
      end
      default: bad = 1'b1;
    endcase
    payload.rd = payload.reg_write ? instr[11:7] : 5'd0;
    if (bad) begin
      payload = '0;
      payload.pc = pc;
`ifdef ILLEGAL_TRAP_EN
      payload.illegal = 1'b1;
`endif
    end
  end
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: registered ID->EX issue stage with a 2-entry (main + skid) buffer
// Ports: clk, rst_n (async active-low), flush, bus (alu_issue_stage_if.slave: in/out valid-ready + payload).
// Optional ILLEGAL_TRAP_EN drives bus.illegal alongside outValid.
module alu_issue_stage #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic rst_n,
  input logic flush,
  alu_issue_stage_if.slave bus
);
  import riscv_pkg::*;
  issue_t dec, main_q, skid_q;
  logic main_v, skid_v, in_fire;
  alu_issue_decode u_dec (
    .instr(bus.instr),
    .pc(bus.pc),
    .rs1_data(bus.rs1Data),
    .rs2_data(bus.rs2Data),
    .payload(dec)
  );
  // inReady depends only on the registered skid flag, so no combinational path from outReady
  assign in_fire = bus.inValid & ~skid_v;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_q <= '0;
      main_q.pc <= RESET_PC;
      skid_q <= '0;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (!main_v || bus.outReady) begin
      main_v <= skid_v | in_fire;
      skid_v <= 1'b0;
      if (skid_v) main_q <= skid_q;
      else if (in_fire) main_q <= dec;
    end else if (in_fire) begin
      skid_q <= dec;
      skid_v <= 1'b1;
    end
  end
  assign bus.inReady = ~skid_v;
  assign bus.outValid = main_v;
  assign bus.srca = main_q.srca;
  assign bus.srcb = main_q.srcb;
  assign bus.aluCtrl = main_q.alu_ctrl;
  assign bus.imm = main_q.imm;
  assign bus.storeData = main_q.store_data;
  assign bus.pcOut = main_q.pc;
  assign bus.rd = main_q.rd;
  assign bus.regWrite = main_q.reg_write;
  assign bus.memRead = main_q.mem_read;
  assign bus.memWrite = main_q.mem_write;
  assign bus.isBranch = main_q.is_branch;
  assign bus.isJump = main_q.is_jump;
`ifdef ILLEGAL_TRAP_EN
  assign bus.illegal = main_q.illegal;
`endif
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: scoreboard bench for alu_issue_stage
module tb_alu_issue_stage;
  localparam logic [31:0] RST_PC = 32'h0000_0200;
  localparam logic [4:0] RW = 5'b10000, MR = 5'b01000, MW = 5'b00100, BR = 5'b00010, JP = 5'b00001;
`ifdef ILLEGAL_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif
  typedef struct packed {
    logic [31:0] srca, srcb, imm, sd, pc;
    logic [5:0] alu;
    logic [4:0] rd;
    logic [4:0] flags;
    logic ill;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  exp_t sb[$];
  exp_t pend;
  int checks = 0, failures = 0, ticks = 0;
  alu_issue_stage_if bus();
  alu_issue_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus));
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [5:0] alu, input logic [31:0] srca, srcb, imm, sd, pc,
                              input logic [4:0] rd, input logic [4:0] flags, input logic ill);
    mk = '{srca: srca, srcb: srcb, imm: imm, sd: sd, pc: pc, alu: alu, rd: rd, flags: flags, ill: ill};
  endfunction

  function automatic exp_t observed();
    observed = '{srca: bus.srca, srcb: bus.srcb, imm: bus.imm, sd: bus.storeData, pc: bus.pcOut,
                 alu: bus.aluCtrl, rd: bus.rd,
                 flags: {bus.regWrite, bus.memRead, bus.memWrite, bus.isBranch, bus.isJump},
`ifdef ILLEGAL_TRAP_EN
                 ill: bus.illegal};
`else
                 ill: 1'b0};
`endif
  endfunction

  task automatic tick(input string tag);
    exp_t e, g;
    if (bus.outValid && bus.outReady) begin
      checks++;
      g = observed();
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL %s unexpected_output got=%h", tag, g);
      end else begin
        e = sb.pop_front();
        if (g !== e) begin
          failures++;
          $display("FAIL %s payload got=%h exp=%h", tag, g, e);
        end
      end
    end
    if (flush) sb.delete();
    else if (bus.inValid && bus.inReady) sb.push_back(pend);
    ticks++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] i, pc, r1, r2, input exp_t e, input string tag);
    int n = 0;
    bus.instr = i;
    bus.pc = pc;
    bus.rs1Data = r1;
    bus.rs2Data = r2;
    bus.inValid = 1'b1;
    pend = e;
    while (!bus.inReady && n < 20) begin
      tick(tag);
      n++;
    end
    checks++;
    if (!bus.inReady) begin
      failures++;
      $display("FAIL %s accept_timeout inReady=%b required=1", tag, bus.inReady);
    end else tick(tag);
  endtask

  task automatic drain(input string tag);
    bus.inValid = 1'b0;
    bus.outReady = 1'b1;
    repeat (4) tick(tag);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_drain pending=%0d required=0", tag, sb.size());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({bus.outValid, bus.inReady} !== 2'b01) begin
      failures++;
      $display("FAIL %s valid_ready got=%b required=01", tag, {bus.outValid, bus.inReady});
    end
    checks++;
    if (observed() !== mk(6'd0, 0, 0, 0, 0, RST_PC, 5'd0, 5'd0, 1'b0)) begin
      failures++;
      $display("FAIL %s payload got=%h required=%h", tag, observed(),
               mk(6'd0, 0, 0, 0, 0, RST_PC, 5'd0, 5'd0, 1'b0));
    end
  endtask

  task automatic test_reset();
    bus.inValid = 1'b0;
    bus.outReady = 1'b0;
    bus.instr = '0;
    bus.pc = '0;
    bus.rs1Data = '0;
    bus.rs2Data = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_decode();
    bus.outReady = 1'b1;
    send(32'h002081B3, 32'h10, 32'd5, 32'd7, mk(6'd0, 5, 7, 0, 0, 32'h10, 5'd3, RW, 1'b0), "add");
    checks++;
    if (bus.outValid !== 1'b1) begin
      failures++;
      $display("FAIL add_latency outValid=%b required=1", bus.outValid);
    end
    send(32'h40315093, 32'h14, 32'h80000000, 32'd0,
         mk(6'd5, 32'h80000000, 3, 32'h403, 0, 32'h14, 5'd1, RW, 1'b0), "srai");
    send(32'h00208463, 32'h18, 32'd9, 32'd9, mk(6'd9, 9, 9, 8, 0, 32'h18, 5'd0, BR, 1'b0), "beq");
    send(32'h4020D233, 32'h1C, 32'hF0, 32'h123, mk(6'd5, 32'hF0, 3, 0, 0, 32'h1C, 5'd4, RW, 1'b0), "sra");
    send(32'h0020A623, 32'h20, 32'h1000, 32'hDEAD,
         mk(6'd0, 32'h1000, 12, 12, 32'hDEAD, 32'h20, 5'd0, MW, 1'b0), "sw");
    send(32'h123452B7, 32'h24, 32'd1, 32'd2,
         mk(6'd0, 0, 32'h12345000, 32'h12345000, 0, 32'h24, 5'd5, RW, 1'b0), "lui");
    send(32'h010000EF, 32'h100, 32'd1, 32'd2, mk(6'd0, 32'h100, 4, 16, 0, 32'h100, 5'd1, RW | JP, 1'b0), "jal");
    send(32'h0000007F, 32'h104, 32'd3, 32'd4, mk(6'd0, 0, 0, 0, 0, 32'h104, 5'd0, 5'd0, TRAP), "opc7f");
    send(32'h022081B3, 32'h108, 32'd6, 32'd8,
         TRAP ? mk(6'd0, 0, 0, 0, 0, 32'h108, 5'd0, 5'd0, 1'b1)
              : mk(6'd0, 6, 8, 0, 0, 32'h108, 5'd3, RW, 1'b0), "op_f7_01");
    drain("decode");
  endtask

  task automatic test_back_to_back();
    bus.outReady = 1'b0;
    send(32'h002080B3, 32'h200, 32'h11, 32'h100, mk(6'd0, 32'h11, 32'h100, 0, 0, 32'h200, 5'd1, RW, 1'b0), "b2b_w1");
    checks++;
    if (bus.inReady !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ready1 inReady=%b required=1", bus.inReady);
    end
    send(32'h00208133, 32'h204, 32'h22, 32'h100, mk(6'd0, 32'h22, 32'h100, 0, 0, 32'h204, 5'd2, RW, 1'b0), "b2b_w2");
    checks++;
    if ({bus.inReady, bus.outValid} !== 2'b01) begin
      failures++;
      $display("FAIL b2b_ready2 inReady_outValid=%b required=01", {bus.inReady, bus.outValid});
    end
    bus.outReady = 1'b1;
    send(32'h002081B3, 32'h208, 32'h33, 32'h100, mk(6'd0, 32'h33, 32'h100, 0, 0, 32'h208, 5'd3, RW, 1'b0), "b2b_w3");
    drain("b2b");
    ticks = 0;
    for (int k = 0; k < 4; k++)
      send(32'h002081B3, 32'h300 + 4 * k, k, 32'h7, mk(6'd0, k, 7, 0, 0, 32'h300 + 4 * k, 5'd3, RW, 1'b0), "stream");
    checks++;
    if (ticks != 4) begin
      failures++;
      $display("FAIL stream_throughput cycles=%0d required=4", ticks);
    end
    drain("stream");
  endtask

  task automatic test_flush();
    bus.outReady = 1'b0;
    send(32'h002080B3, 32'h400, 1, 2, mk(6'd0, 1, 2, 0, 0, 32'h400, 5'd1, RW, 1'b0), "fl_a");
    send(32'h00208133, 32'h404, 3, 4, mk(6'd0, 3, 4, 0, 0, 32'h404, 5'd2, RW, 1'b0), "fl_b");
    flush = 1'b1;
    tick("flush_full");
    flush = 1'b0;
    checks++;
    if ({bus.outValid, bus.inReady} !== 2'b01) begin
      failures++;
      $display("FAIL flush_full valid_ready got=%b required=01", {bus.outValid, bus.inReady});
    end
    bus.inValid = 1'b0;
    bus.outReady = 1'b1;
    repeat (3) tick("flush_quiet");
    flush = 1'b1;
    send(32'h002081B3, 32'h408, 5, 6, mk(6'd0, 5, 6, 0, 0, 32'h408, 5'd3, RW, 1'b0), "flush_in");
    flush = 1'b0;
    bus.inValid = 1'b0;
    checks++;
    if (bus.outValid !== 1'b0) begin
      failures++;
      $display("FAIL flush_drop outValid=%b required=0", bus.outValid);
    end
    send(32'h002081B3, 32'h40C, 7, 8, mk(6'd0, 7, 8, 0, 0, 32'h40C, 5'd3, RW, 1'b0), "flush_after");
    drain("flush");
  endtask

  task automatic test_reset_mid_stall();
    bus.outReady = 1'b0;
    send(32'h002080B3, 32'h500, 1, 2, mk(6'd0, 1, 2, 0, 0, 32'h500, 5'd1, RW, 1'b0), "rs_a");
    send(32'h00208133, 32'h504, 3, 4, mk(6'd0, 3, 4, 0, 0, 32'h504, 5'd2, RW, 1'b0), "rs_b");
    bus.inValid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset_mid");
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.outReady = 1'b1;
    send(32'h002081B3, 32'h508, 9, 1, mk(6'd0, 9, 1, 0, 0, 32'h508, 5'd3, RW, 1'b0), "rs_after");
    drain("reset_mid");
  endtask

  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_flush();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time_limit_reached");
    $fatal(1, "watchdog");
  end
endmodule
